// File: rtl/main_memory_model.sv
// Word-organised backing memory with fixed read/write latency behind the L2 arbiter.
// Optional MAIN_MEM_STATS_EN adds saturating completed-read/write counters (rd_count, wr_count).
module main_memory_model #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter int unsigned READ_LATENCY   = 4,
    parameter int unsigned WRITE_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_read_req,
    input  logic                  mem_write_req,
    output logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_ready,
    output logic                  mem_busy
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
`endif
);

    localparam int unsigned DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [CNT_W-1:0]          count_q;
    logic [CNT_W-1:0]          count_d;
    logic [MEM_DEPTH_LOG2-1:0] idx_q;
    logic [MEM_DEPTH_LOG2-1:0] addr_idx;
    logic [MEM_DEPTH_LOG2-1:0] rd_idx;
    logic                      is_read_q;
    logic                      accept_rd;
    logic                      accept_wr;
    logic                      sample_rd;
    logic [DATA_WIDTH-1:0]     mem [DEPTH];

    // Upper address bits and byte offset are deliberately dropped (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_address[ADDR_WIDTH-1:MEM_DEPTH_LOG2+2], mem_address[1:0]};
    assign addr_idx         = mem_address[MEM_DEPTH_LOG2+1:2];

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            idx_q         <= '0;
            is_read_q     <= 1'b0;
            mem_ready     <= 1'b0;
            mem_busy      <= 1'b0;
            mem_read_data <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mem_ready <= (state_d == S_DONE);
            mem_busy  <= (state_d != S_IDLE);
            if (accept_rd || accept_wr) begin
                idx_q     <= addr_idx;
                is_read_q <= accept_rd;
            end
            if (sample_rd) begin
                mem_read_data <= mem[rd_idx];
            end
        end
    end

    // Next-state and latency counter
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (accept_rd) begin
                    count_d = CNT_W'(READ_LATENCY - 1);
                    state_d = (READ_LATENCY == 1) ? S_DONE : S_BUSY;
                end else if (accept_wr) begin
                    count_d = CNT_W'(WRITE_LATENCY - 1);
                    state_d = (WRITE_LATENCY == 1) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (count_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request acceptance and read-sample decode; read has priority over write
    always_comb begin
        accept_rd = 1'b0;
        accept_wr = 1'b0;
        sample_rd = 1'b0;
        rd_idx    = idx_q;
        if (state_q == S_IDLE) begin
            accept_rd = mem_read_req;
            accept_wr = mem_write_req && !mem_read_req;
        end
        if (accept_rd && (READ_LATENCY == 1)) begin
            sample_rd = 1'b1;
            rd_idx    = addr_idx;
        end else if ((state_q == S_BUSY) && is_read_q && (count_q == '0)) begin
            sample_rd = 1'b1;
        end
    end

    // Array write commits on the accepting edge, so a later reset cannot undo it
    always_ff @(posedge clk) begin
        if (!reset && accept_wr) begin
            mem[addr_idx] <= mem_write_data;
        end
    end

`ifdef MAIN_MEM_STATS_EN
    // Completed-transaction counters, saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state_q == S_DONE) begin
            if (is_read_q && (rd_count != 32'hFFFF_FFFF)) begin
                rd_count <= rd_count + 32'd1;
            end
            if (!is_read_q && (wr_count != 32'hFFFF_FFFF)) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_main_memory_model.sv
// Directed bench for main_memory_model with a scoreboard of expected completions.
module tb_main_memory_model;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read_req;
    logic        mem_write_req;
    logic [31:0] mem_read_data;
    logic        mem_ready;
    logic        mem_busy;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    main_memory_model dut (
        .clk           (clk),
        .reset         (reset),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_req  (mem_read_req),
        .mem_write_req (mem_write_req),
        .mem_read_data (mem_read_data),
        .mem_ready     (mem_ready),
        .mem_busy      (mem_busy)
`ifdef MAIN_MEM_STATS_EN
        ,
        .rd_count      (rd_count),
        .wr_count      (wr_count)
`endif
    );

`ifndef MAIN_MEM_STATS_EN
    assign rd_count = '0;
    assign wr_count = '0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          known;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model[int];
    int          total = 0;
    int          bad   = 0;
    int          n_rd  = 0;
    int          n_wr  = 0;
    logic [31:0] last_rd    = '0;
    bit          last_known = 1'b1;

    localparam int unsigned RD_LAT = 4;
    localparam int unsigned WR_LAT = 2;

    function automatic int key(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit rd, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.rd    = rd;
        e.known = rd ? model.exists(key(addr)) : 1'b1;
        e.data  = (rd && e.known) ? model[key(addr)] : data;
        if (!rd) model[key(addr)] = data;
        sb.push_back(e);
    endtask

    // Wait (bounded) for mem_ready after an accept edge, then retire one scoreboard entry
    task automatic wait_done(input string tag, input int unsigned lat);
        int   n;
        exp_t e;
        n = 0;
        while (!mem_ready && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.rd) begin
                if (e.known) check({tag, "_rdata"}, mem_read_data, e.data);
                last_rd    = e.data;
                last_known = e.known;
                n_rd++;
            end else begin
                if (last_known) check({tag, "_rdata_held"}, mem_read_data, last_rd);
                n_wr++;
            end
        end
    endtask

    // One complete transaction: drive, accept, ignore-inputs-while-busy, complete, pulse ends
    task automatic txn(input string tag, input bit rd, input logic [31:0] addr, input logic [31:0] data);
        mem_address    = addr;
        mem_write_data = data;
        mem_read_req   = rd;
        mem_write_req  = !rd;
        push_exp(rd, addr, data);
        @(posedge clk); #1;
        check({tag, "_busy_on_accept"}, 32'(mem_busy), 32'd1);
        mem_address    = 32'hFFFF_FFFC;
        mem_write_data = 32'h0BAD_0BAD;
        wait_done(tag, rd ? RD_LAT : WR_LAT);
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ready_one_cycle"}, 32'(mem_ready), 32'd0);
        check({tag, "_busy_cleared"}, 32'(mem_busy), 32'd0);
    endtask

    task automatic do_reset_pulse();
        reset = 1'b1;
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        n_rd = 0;
        n_wr = 0;
        last_rd    = '0;
        last_known = 1'b1;
        check("post_reset_rdata", mem_read_data, 32'd0);
        check("post_reset_busy", 32'(mem_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        mem_address    = 32'h0;
        mem_write_data = 32'h0;
        mem_read_req   = 1'b1;
        mem_write_req  = 1'b0;

        // Reset held with a read pending: nothing happens
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_ready", 32'(mem_ready), 32'd0);
            check("rst_busy", 32'(mem_busy), 32'd0);
            check("rst_rdata", mem_read_data, 32'd0);
        end
        reset = 1'b0;
        txn("first_read", 1'b1, 32'h0, 32'h0);

        // Write then read back
        txn("wr_deadbeef", 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        txn("rd_deadbeef", 1'b1, 32'h0000_0010, 32'h0);
        check("rd_deadbeef_const", last_rd, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check("rdata_held_idle", mem_read_data, 32'hDEAD_BEEF);

        // Simultaneous read and write: read first, write in a later IDLE cycle
        mem_address    = 32'h10;
        mem_write_data = 32'h1234_5678;
        mem_read_req   = 1'b1;
        mem_write_req  = 1'b1;
        push_exp(1'b1, 32'h10, 32'h0);
        @(posedge clk); #1;
        check("simul_busy", 32'(mem_busy), 32'd1);
        wait_done("simul_read", RD_LAT);
        mem_read_req = 1'b0;
        mem_address  = 32'h20;
        push_exp(1'b0, 32'h20, 32'h1234_5678);
        @(posedge clk); #1;
        check("simul_idle_gap_busy", 32'(mem_busy), 32'd0);
        check("simul_idle_gap_ready", 32'(mem_ready), 32'd0);
        @(posedge clk); #1;
        check("simul_write_accepted", 32'(mem_busy), 32'd1);
        wait_done("simul_write", WR_LAT);
        mem_write_req = 1'b0;
        @(posedge clk); #1;
        txn("rd_after_simul", 1'b1, 32'h20, 32'h0);
        check("rd_after_simul_const", last_rd, 32'h1234_5678);
        txn("rd_0x10_intact", 1'b1, 32'h10, 32'h0);

        // Aliasing of upper address bits
        txn("alias_wr", 1'b0, 32'h0000_1004, 32'hA5A5_A5A5);
        txn("alias_rd", 1'b1, 32'h0000_0004, 32'h0);
        check("alias_rd_const", last_rd, 32'hA5A5_A5A5);

        // Reset two cycles into a read: no completion
        mem_address  = 32'h10;
        mem_read_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrd_no_early_ready", 32'(mem_ready), 32'd0);
        do_reset_pulse();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrd_no_ready", 32'(mem_ready), 32'd0);
        end
        txn("rd_after_abort", 1'b1, 32'h20, 32'h0);

        // Reset right after a write is accepted: the write persists
        mem_address    = 32'h40;
        mem_write_data = 32'h55AA_55AA;
        mem_write_req  = 1'b1;
        model[key(32'h40)] = 32'h55AA_55AA;
        @(posedge clk); #1;
        do_reset_pulse();
        @(posedge clk); #1;
        check("midwr_no_ready", 32'(mem_ready), 32'd0);
        txn("rd_committed", 1'b1, 32'h40, 32'h0);
        check("rd_committed_const", last_rd, 32'h55AA_55AA);

`ifdef MAIN_MEM_STATS_EN
        do_reset_pulse();
        check("stats_rd_reset", rd_count, 32'd0);
        check("stats_wr_reset", wr_count, 32'd0);
        for (int i = 0; i < 3; i++) txn("stats_wr", 1'b0, 32'h100 + 32'(i * 4), 32'h1000 + 32'(i));
        for (int i = 0; i < 5; i++) txn("stats_rd", 1'b1, 32'h100 + 32'((i % 3) * 4), 32'h0);
        check("stats_rd_count", rd_count, 32'd5);
        check("stats_wr_count", wr_count, 32'd3);
        check("stats_rd_model", rd_count, 32'(n_rd));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
